// File: rtl/mem_access_stage.sv
// EX/MEM pipeline register and MEM stage: word loads/stores over a req/ack data memory,
// pipeline freeze while an access is outstanding, timeout abort, and the MEM/WB register.
module mem_access_stage #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [DATA_W-1:0]  ex_alu_res_i,
    input  logic [DATA_W-1:0]  ex_store_data_i,
    input  logic [RADDR_W-1:0] ex_rd_addr_i,
    input  logic               ex_regwrite_i,
    input  logic               ex_memtoreg_i,
    input  logic               ex_memread_i,
    input  logic               ex_memwrite_i,
    output logic               stall_o,
    output logic [DATA_W-1:0]  fwd_alu_res_o,
    output logic [RADDR_W-1:0] fwd_rd_addr_o,
    output logic               fwd_regwrite_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [DATA_W-1:0]  dmem_addr_o,
    output logic [DATA_W-1:0]  dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [DATA_W-1:0]  dmem_rdata_i,
    output logic               wb_regwrite_o,
    output logic               wb_memtoreg_o,
    output logic [RADDR_W-1:0] wb_rd_addr_o,
    output logic [DATA_W-1:0]  wb_alu_res_o,
    output logic [DATA_W-1:0]  wb_mem_data_o,
    output logic               mem_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DATA_W-1:0]  exm_alu_res;
    logic [DATA_W-1:0]  exm_store_data;
    logic [RADDR_W-1:0] exm_rd_addr;
    logic               exm_regwrite;
    logic               exm_memtoreg;
    logic               exm_memread;
    logic               exm_memwrite;

    logic memop;
    logic misaligned;
    logic aligned_memop;
    logic abort;

    // A load with memwrite also set behaves as a load, so memread alone selects the direction.
    assign memop         = exm_memread | exm_memwrite;
    assign misaligned    = memop & (exm_alu_res[1:0] != 2'b00);
    assign aligned_memop = memop & ~misaligned;
    assign abort         = aligned_memop & (state_q == ST_WAIT) & (cnt_q == LAST_WAIT) & ~dmem_ack_i;

    assign stall_o       = aligned_memop & ~dmem_ack_i & ~abort;
    assign mem_err_o     = misaligned | abort;

    assign dmem_req_o    = aligned_memop;
    assign dmem_we_o     = aligned_memop & exm_memwrite & ~exm_memread;
    assign dmem_addr_o   = {exm_alu_res[DATA_W-1:2], 2'b00};
    assign dmem_wdata_o  = exm_store_data;

    assign fwd_alu_res_o  = exm_alu_res;
    assign fwd_rd_addr_o  = exm_rd_addr;
    assign fwd_regwrite_o = exm_regwrite;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter tracks how many request cycles have already elapsed for the access in flight.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (aligned_memop && !dmem_ack_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (dmem_ack_i || abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            exm_alu_res    <= '0;
            exm_store_data <= '0;
            exm_rd_addr    <= '0;
            exm_regwrite   <= 1'b0;
            exm_memtoreg   <= 1'b0;
            exm_memread    <= 1'b0;
            exm_memwrite   <= 1'b0;
        end else if (!stall_o) begin
            exm_alu_res    <= ex_alu_res_i;
            exm_store_data <= ex_store_data_i;
            exm_rd_addr    <= ex_rd_addr_i;
            exm_regwrite   <= ex_regwrite_i;
            exm_memtoreg   <= ex_memtoreg_i;
            exm_memread    <= ex_memread_i;
            exm_memwrite   <= ex_memwrite_i;
        end
    end

    // Misaligned and aborted accesses still retire, but with their register write suppressed.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_regwrite_o <= 1'b0;
            wb_memtoreg_o <= 1'b0;
            wb_rd_addr_o  <= '0;
            wb_alu_res_o  <= '0;
            wb_mem_data_o <= '0;
        end else if (stall_o) begin
            wb_regwrite_o <= 1'b0;
        end else begin
            wb_regwrite_o <= exm_regwrite & ~misaligned & ~abort;
            wb_memtoreg_o <= exm_memtoreg;
            wb_rd_addr_o  <= exm_rd_addr;
            wb_alu_res_o  <= exm_alu_res;
            if (aligned_memop && exm_memread && dmem_ack_i) begin
                wb_mem_data_o <= dmem_rdata_i;
            end
        end
    end

endmodule
